// File: rtl/unit_test_result_writer_pkg.sv
// Shared types for the unit-test result writer: record kinds, record entry and FSM states.
// UT_RESULT_TIMESTAMP_EN adds a 16-bit timestamp field to every record entry.
package unit_test_hw_pkg;

  typedef enum logic [1:0] {
    REC_START    = 2'd0,
    REC_FAIL     = 2'd1,
    REC_SUM_PASS = 2'd2,
    REC_SUM_FAIL = 2'd3
  } rec_kind_e;

  typedef struct packed {
`ifdef UT_RESULT_TIMESTAMP_EN
    logic [15:0] ts;
`endif
    rec_kind_e   kind;
    logic [31:0] data;
  } rec_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_SUM_P = 2'd2,
    ST_SUM_F = 2'd3
  } state_e;

endpackage

// File: rtl/unit_test_result_writer_if.sv
// Record stream between the result writer (master) and the bench-side logger (slave).
// UT_RESULT_TIMESTAMP_EN adds the rec_ts signal.
interface unit_test_result_writer_if;
  logic        rec_valid;
  logic        rec_ready;
  logic [1:0]  rec_kind;
  logic [31:0] rec_data;
`ifdef UT_RESULT_TIMESTAMP_EN
  logic [15:0] rec_ts;

  modport master (output rec_valid, output rec_kind, output rec_data, output rec_ts, input rec_ready);
  modport slave  (input rec_valid, input rec_kind, input rec_data, input rec_ts, output rec_ready);
`else
  modport master (output rec_valid, output rec_kind, output rec_data, input rec_ready);
  modport slave  (input rec_valid, input rec_kind, input rec_data, output rec_ready);
`endif
endinterface

// File: rtl/unit_test_result_writer_rec_fifo.sv
// First-word fall-through record FIFO; head reads as all-zero while empty.
// Push while full is accepted only when a pop happens in the same cycle.
module unit_test_rec_fifo
  import unit_test_hw_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  rec_t data_i,
  input  logic pop_i,
  output rec_t data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  rec_t            mem_q [DEPTH];
  logic [AW-1:0]   wr_q;
  logic [AW-1:0]   rd_q;
  logic [AW:0]     cnt_q;
  logic            push_ok;
  logic            pop_ok;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i & (!full_o | pop_i);
  assign pop_ok  = pop_i & !empty_o;
  assign data_o  = empty_o ? '0 : mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) begin
        wr_q <= wr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_q <= rd_q + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/unit_test_result_writer.sv
// Unit-test result writer: counts checker events and streams START/FAIL/SUMMARY records.
// Optional macro UT_RESULT_TIMESTAMP_EN stamps each record with a 16-bit cycle count.
module unit_test_result_writer
  import unit_test_hw_pkg::*;
#(
  parameter int ID_W  = 16,
  parameter int CNT_W = 16,
  parameter int DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  input  logic [ID_W-1:0]             test_num_i,
  input  logic                        finish_i,
  input  logic                        check_valid_i,
  input  logic                        check_pass_i,
  input  logic [ID_W-1:0]             check_id_i,
  unit_test_result_writer_if.master   rec_if,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        overflow_o,
  output logic                        proto_err_o
);

  state_e           state_q;
  logic [CNT_W-1:0] pass_cnt_q;
  logic [CNT_W-1:0] fail_cnt_q;
  logic             done_q;
  logic             overflow_q;
  logic             proto_err_q;
  logic             push_s;
  logic             accept_s;
  logic             pop_s;
  logic             full_s;
  logic             empty_s;
  rec_t             push_rec_s;
  rec_t             head_s;

`ifdef UT_RESULT_TIMESTAMP_EN
  logic [15:0] ts_q;
  logic [15:0] ts_d;

  // Stamp is the counter value after the push edge, so START carries 0.
  always_comb begin
    if (state_q == ST_IDLE) begin
      ts_d = start_i ? 16'd0 : ts_q;
    end else begin
      ts_d = ts_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_q <= 16'd0;
    end else begin
      ts_q <= ts_d;
    end
  end

  assign rec_if.rec_ts = head_s.ts;
`endif

  // Record to push this cycle; summary states only request a push when there is space.
  always_comb begin
    push_s     = 1'b0;
    push_rec_s = '0;
    case (state_q)
      ST_IDLE: begin
        push_s          = start_i;
        push_rec_s.kind = REC_START;
        push_rec_s.data = 32'(test_num_i);
      end
      ST_RUN: begin
        push_s          = check_valid_i & !check_pass_i;
        push_rec_s.kind = REC_FAIL;
        push_rec_s.data = 32'(check_id_i);
      end
      ST_SUM_P: begin
        push_s          = !full_s;
        push_rec_s.kind = REC_SUM_PASS;
        push_rec_s.data = 32'(pass_cnt_q);
      end
      ST_SUM_F: begin
        push_s          = !full_s;
        push_rec_s.kind = REC_SUM_FAIL;
        push_rec_s.data = 32'(fail_cnt_q);
      end
      default: begin
        push_s     = 1'b0;
        push_rec_s = '0;
      end
    endcase
`ifdef UT_RESULT_TIMESTAMP_EN
    push_rec_s.ts = ts_d;
`endif
  end

  assign pop_s    = !empty_s & rec_if.rec_ready;
  assign accept_s = push_s & (!full_s | pop_s);

  unit_test_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .data_i  (push_rec_s),
    .pop_i   (pop_s),
    .data_o  (head_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Test sequencing FSM with saturating counters and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            state_q    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (start_i) begin
            proto_err_q <= 1'b1;
          end
          if (check_valid_i) begin
            if (check_pass_i) begin
              if (pass_cnt_q != '1) begin
                pass_cnt_q <= pass_cnt_q + CNT_W'(1);
              end
            end else begin
              if (fail_cnt_q != '1) begin
                fail_cnt_q <= fail_cnt_q + CNT_W'(1);
              end
              if (!accept_s) begin
                overflow_q <= 1'b1;
              end
            end
          end
          if (finish_i) begin
            state_q <= ST_SUM_P;
          end
        end
        ST_SUM_P: begin
          if (start_i) begin
            proto_err_q <= 1'b1;
          end
          if (!full_s) begin
            state_q <= ST_SUM_F;
          end
        end
        ST_SUM_F: begin
          if (start_i) begin
            proto_err_q <= 1'b1;
          end
          if (!full_s) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rec_if.rec_valid = !empty_s;
  assign rec_if.rec_kind  = head_s.kind;
  assign rec_if.rec_data  = head_s.data;
  assign busy_o           = (state_q != ST_IDLE);
  assign done_o           = done_q;
  assign overflow_o       = overflow_q;
  assign proto_err_o      = proto_err_q;

endmodule

// File: tb/tb_unit_test_result_writer.sv
// Directed bench for unit_test_result_writer; a second instance with CNT_W=4 covers saturation.
// Timestamp checks are compiled in when UT_RESULT_TIMESTAMP_EN is defined.
module tb_unit_test_result_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [15:0] test_num_i;
  logic        finish_i;
  logic        check_valid_i;
  logic        check_pass_i;
  logic [15:0] check_id_i;
  logic        busy1, done1, ovf1, perr1;
  logic        busy2, done2, ovf2, perr2;
  int          checks = 0;
  int          failures = 0;

  unit_test_result_writer_if rif ();
  unit_test_result_writer_if rif2 ();

  assign rif2.rec_ready = rif.rec_ready;

  always #5 clk = ~clk;

  unit_test_result_writer #(.ID_W(16), .CNT_W(16), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .test_num_i(test_num_i),
    .finish_i(finish_i), .check_valid_i(check_valid_i), .check_pass_i(check_pass_i),
    .check_id_i(check_id_i), .rec_if(rif), .busy_o(busy1), .done_o(done1),
    .overflow_o(ovf1), .proto_err_o(perr1)
  );

  unit_test_result_writer #(.ID_W(16), .CNT_W(4), .DEPTH(8)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .test_num_i(test_num_i),
    .finish_i(finish_i), .check_valid_i(check_valid_i), .check_pass_i(check_pass_i),
    .check_id_i(check_id_i), .rec_if(rif2), .busy_o(busy2), .done_o(done2),
    .overflow_o(ovf2), .proto_err_o(perr2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the head record of the main instance, then pop it.
  task automatic pop_chk(input string tag, input logic [1:0] kind, input logic [31:0] data);
    rif.rec_ready = 1'b1;
    chk({tag, "_valid"}, 32'(rif.rec_valid), 32'd1);
    chk({tag, "_kind"}, 32'(rif.rec_kind), 32'(kind));
    chk({tag, "_data"}, rif.rec_data, data);
    step();
    rif.rec_ready = 1'b0;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, 32'(rif.rec_valid), 32'd0);
    chk({tag, "_kind"}, 32'(rif.rec_kind), 32'd0);
    chk({tag, "_data"}, rif.rec_data, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; test_num_i = 16'd0; finish_i = 1'b0;
    check_valid_i = 1'b0; check_pass_i = 1'b0; check_id_i = 16'd0;
    rif.rec_ready = 1'b0;
    step(); step();

    // Reset state
    chk_empty("rst");
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_ovf", 32'(ovf1), 32'd0);
    chk("rst_perr", 32'(perr1), 32'd0);
    rst_n = 1'b1;
    step();

    // Test 1: three passes
    start_i = 1'b1; test_num_i = 16'h0012; step(); start_i = 1'b0;
    chk("t1_busy_run", 32'(busy1), 32'd1);
    chk("t1_valid_lat", 32'(rif.rec_valid), 32'd1);
    check_valid_i = 1'b1; check_pass_i = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check_valid_i = 1'b0;
    finish_i = 1'b1; step(); finish_i = 1'b0;
    step();
    chk("t1_busy_sumf", 32'(busy1), 32'd1);
    chk("t1_done_early", 32'(done1), 32'd0);
    step();
    chk("t1_done_pulse", 32'(done1), 32'd1);
    chk("t1_busy_idle", 32'(busy1), 32'd0);
    step();
    chk("t1_done_clear", 32'(done1), 32'd0);
    pop_chk("t1_start", 2'd0, 32'h12);
    pop_chk("t1_sump", 2'd2, 32'd3);
    pop_chk("t1_sumf", 2'd3, 32'd0);
    chk_empty("t1_empty");

    // Test 2: two fails and one pass
    start_i = 1'b1; test_num_i = 16'h0034; step(); start_i = 1'b0;
    check_valid_i = 1'b1; check_pass_i = 1'b0;
    check_id_i = 16'd5; step();
    check_id_i = 16'd9; step();
    check_pass_i = 1'b1; step();
    check_valid_i = 1'b0;
    finish_i = 1'b1; step(); finish_i = 1'b0;
    step(); step(); step();
    pop_chk("t2_start", 2'd0, 32'h34);
    pop_chk("t2_fail5", 2'd1, 32'd5);
    pop_chk("t2_fail9", 2'd1, 32'd9);
    pop_chk("t2_sump", 2'd2, 32'd1);
    pop_chk("t2_sumf", 2'd3, 32'd2);
    chk_empty("t2_empty");
    chk("t2_ovf", 32'(ovf1), 32'd0);

    // Test 3: ten fails into a stalled logger
    start_i = 1'b1; test_num_i = 16'h0078; step(); start_i = 1'b0;
    check_valid_i = 1'b1; check_pass_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check_id_i = 16'(256 + i);
      step();
    end
    check_valid_i = 1'b0;
    finish_i = 1'b1; step(); finish_i = 1'b0;
    step(); step(); step();
    chk("t3_ovf", 32'(ovf1), 32'd1);
    chk("t3_busy_stall", 32'(busy1), 32'd1);
    chk("t3_done_stall", 32'(done1), 32'd0);
    pop_chk("t3_start", 2'd0, 32'h78);
    for (int i = 0; i < 7; i++) begin
      pop_chk("t3_fail", 2'd1, 32'(256 + i));
    end
    pop_chk("t3_sump", 2'd2, 32'd0);
    pop_chk("t3_sumf", 2'd3, 32'd10);
    step(); step();
    chk_empty("t3_empty");
    chk("t3_busy_idle", 32'(busy1), 32'd0);
    chk("t3_ovf_sticky", 32'(ovf1), 32'd1);

    // Test 4: 20 passes, CNT_W=4 instance saturates at 15
    start_i = 1'b1; test_num_i = 16'h0056; step(); start_i = 1'b0;
    check_valid_i = 1'b1; check_pass_i = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check_valid_i = 1'b0;
    finish_i = 1'b1; step(); finish_i = 1'b0;
    step(); step(); step();
    pop_chk("t4_start", 2'd0, 32'h56);
    chk("t4_sat_kind", 32'(rif2.rec_kind), 32'd2);
    chk("t4_sat_data", rif2.rec_data, 32'd15);
    pop_chk("t4_sump", 2'd2, 32'd20);
    chk("t4_sat_sumf", rif2.rec_data, 32'd0);
    pop_chk("t4_sumf", 2'd3, 32'd0);

    // Test 5: protocol error, then reset with queued records
    start_i = 1'b1; test_num_i = 16'h0099; step(); start_i = 1'b0;
    chk("t5_perr_clean", 32'(perr1), 32'd0);
    start_i = 1'b1; step(); start_i = 1'b0;
    chk("t5_perr_set", 32'(perr1), 32'd1);
    step();
    chk("t5_perr_sticky", 32'(perr1), 32'd1);
    check_valid_i = 1'b1; check_pass_i = 1'b0; check_id_i = 16'd3;
    step(); step();
    check_valid_i = 1'b0;
    chk("t5_queued", 32'(rif.rec_valid), 32'd1);
    rst_n = 1'b0; step();
    chk_empty("t5_rst");
    chk("t5_rst_busy", 32'(busy1), 32'd0);
    chk("t5_rst_perr", 32'(perr1), 32'd0);
    chk("t5_rst_ovf", 32'(ovf1), 32'd0);
    chk("t5_rst_done", 32'(done1), 32'd0);
    rst_n = 1'b1; step();

`ifdef UT_RESULT_TIMESTAMP_EN
    // Test 6: timestamps
    chk("t6_ts_rst", 32'(rif.rec_ts), 32'd0);
    start_i = 1'b1; test_num_i = 16'h0001; step(); start_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check_valid_i = 1'b1; check_pass_i = 1'b0; check_id_i = 16'd7; step();
    check_valid_i = 1'b0;
    finish_i = 1'b1; step(); finish_i = 1'b0;
    step(); step(); step();
    chk("t6_ts_start", 32'(rif.rec_ts), 32'd0);
    pop_chk("t6_start", 2'd0, 32'd1);
    chk("t6_ts_fail", 32'(rif.rec_ts), 32'd5);
    pop_chk("t6_fail", 2'd1, 32'd7);
    chk("t6_ts_sump", 32'(rif.rec_ts), 32'd7);
    pop_chk("t6_sump", 2'd2, 32'd0);
    chk("t6_ts_sumf", 32'(rif.rec_ts), 32'd8);
    pop_chk("t6_sumf", 2'd3, 32'd1);
    chk("t6_ts_empty", 32'(rif.rec_ts), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
